// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the backprop network blocks:
// default word/fraction widths, saturation limits, FSM state type and clog2.
package nn_fixed_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 10;

  localparam logic signed [W_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W_DEF-1:0] SAT_MIN = 16'sh8000;

  // ACCUM collects dw samples; APPLY is the single commit cycle.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_APPLY = 1'b1
  } wb_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed add of an OUT_W weight and an IN_W accumulator, clamped to the
// OUT_W two's-complement range. o_ovf flags that the clamp was applied.
module sat_add #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 16
) (
  input  logic signed [OUT_W-1:0] i_a,
  input  logic signed [IN_W-1:0]  i_b,
  output logic signed [OUT_W-1:0] o_sum,
  output logic                    o_ovf
);

  // One guard bit over the wider operand keeps the raw sum exact.
  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

  logic signed [SUM_W-1:0] w_sum;

  assign w_sum = SUM_W'(i_a) + SUM_W'(i_b);

  // Clamp the exact sum into the output range.
  always_comb begin
    o_sum = w_sum[OUT_W-1:0];
    o_ovf = 1'b0;
    if (w_sum > MAX_V) begin
      o_sum = MAX_V[OUT_W-1:0];
      o_ovf = 1'b1;
    end else if (w_sum < MIN_V) begin
      o_sum = MIN_V[OUT_W-1:0];
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/weight_bank.sv
// Bank of N_W signed fixed-point weights. dw samples are summed over BATCH
// accepted transfers, then committed in one APPLY cycle with saturation.
// Handshake: a sample transfers on a rising edge where upd_valid=1 and
// upd_ready=1; upd_ready depends only on registered state, and a sample
// presented while upd_ready=0 is ignored (sources hold upd_valid).
module weight_bank
  import nn_fixed_pkg::*;
#(
  parameter int N_W   = 4,
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int BATCH = 1,
  parameter logic [N_W*W-1:0] INIT_VALS = {N_W{16'h0266}},
  localparam int ACC_W = W + clog2(BATCH),
  localparam int CNT_W = clog2(BATCH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_req,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [N_W*W-1:0]   dw_flat,
  output logic [N_W*W-1:0]   w_flat,
  output logic               w_valid,
  output logic [N_W-1:0]     sat_flag,
  output logic [CNT_W-1:0]   batch_cnt,
  output wb_state_e          dbg_state
);

  if (BATCH < 1 || N_W < 1 || FRAC >= W) begin : g_param_err
    $error("weight_bank: BATCH and N_W must be >= 1 and FRAC < W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

  logic signed [W-1:0]     r_w   [N_W];
  logic signed [ACC_W-1:0] r_acc [N_W];
  logic [CNT_W-1:0]        r_cnt;
  logic [N_W-1:0]          r_sat;
  logic                    r_w_valid;
  wb_state_e               r_state;

  logic signed [W-1:0]     w_dw  [N_W];
  logic signed [W-1:0]     w_sum [N_W];
  logic [N_W-1:0]          w_ovf;

  for (genvar k = 0; k < N_W; k++) begin : g_ch
    assign w_dw[k]          = dw_flat[k*W +: W];
    assign w_flat[k*W +: W] = r_w[k];

    sat_add #(
      .IN_W  (ACC_W),
      .OUT_W (W)
    ) u_sat_add (
      .i_a   (r_w[k]),
      .i_b   (r_acc[k]),
      .o_sum (w_sum[k]),
      .o_ovf (w_ovf[k])
    );
  end

  // Control FSM with accumulators, weights and flags; init_req outranks APPLY.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_W; k++) begin
        r_w[k]   <= '0;
        r_acc[k] <= '0;
      end
      r_cnt     <= '0;
      r_sat     <= '0;
      r_w_valid <= 1'b0;
      r_state   <= ST_ACCUM;
    end else begin
      r_w_valid <= 1'b0;
      if (init_req) begin
        for (int k = 0; k < N_W; k++) begin
          r_w[k]   <= INIT_VALS[k*W +: W];
          r_acc[k] <= '0;
        end
        r_cnt   <= '0;
        r_sat   <= '0;
        r_state <= ST_ACCUM;
      end else begin
        case (r_state)
          ST_ACCUM: begin
            if (upd_valid) begin
              for (int k = 0; k < N_W; k++) begin
                r_acc[k] <= r_acc[k] + ACC_W'(w_dw[k]);
              end
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == LAST_CNT) begin
                r_state <= ST_APPLY;
              end
            end
          end
          ST_APPLY: begin
            for (int k = 0; k < N_W; k++) begin
              r_w[k]   <= w_sum[k];
              r_acc[k] <= '0;
            end
            r_sat     <= r_sat | w_ovf;
            r_cnt     <= '0;
            r_w_valid <= 1'b1;
            r_state   <= ST_ACCUM;
          end
          default: r_state <= ST_ACCUM;
        endcase
      end
    end
  end

  assign upd_ready = (r_state == ST_ACCUM);
  assign w_valid   = r_w_valid;
  assign sat_flag  = r_sat;
  assign batch_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_weight_bank.sv
// Bench for weight_bank: three instances (BATCH=1 default init, BATCH=4
// default init, BATCH=1 with saturation-edge init values) checked against an
// integer-arithmetic model of weights, batch sums and clamping.
module tb_weight_bank;
  import nn_fixed_pkg::*;

  localparam int NI = 3;
  localparam int NW = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [NI];
  logic        init  [NI];
  logic        uv    [NI];
  logic [63:0] dw    [NI];
  logic        rdy   [NI];
  logic [63:0] wf    [NI];
  logic        wv    [NI];
  logic [3:0]  sf    [NI];
  wb_state_e   st    [NI];
  logic [0:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [0:0]  cnt_c;

  int n_checks;
  int n_fail;

  weight_bank #(.N_W(4), .W(16), .FRAC(10), .BATCH(1)) u_b1 (
    .clk(clk), .reset(rst[0]), .init_req(init[0]), .upd_valid(uv[0]),
    .upd_ready(rdy[0]), .dw_flat(dw[0]), .w_flat(wf[0]), .w_valid(wv[0]),
    .sat_flag(sf[0]), .batch_cnt(cnt_a), .dbg_state(st[0])
  );

  weight_bank #(.N_W(4), .W(16), .FRAC(10), .BATCH(4)) u_b4 (
    .clk(clk), .reset(rst[1]), .init_req(init[1]), .upd_valid(uv[1]),
    .upd_ready(rdy[1]), .dw_flat(dw[1]), .w_flat(wf[1]), .w_valid(wv[1]),
    .sat_flag(sf[1]), .batch_cnt(cnt_b), .dbg_state(st[1])
  );

  weight_bank #(.N_W(4), .W(16), .FRAC(10), .BATCH(1),
    .INIT_VALS({16'h0000, 16'h0100, 16'h8010, 16'h7FF0})) u_sat (
    .clk(clk), .reset(rst[2]), .init_req(init[2]), .upd_valid(uv[2]),
    .upd_ready(rdy[2]), .dw_flat(dw[2]), .w_flat(wf[2]), .w_valid(wv[2]),
    .sat_flag(sf[2]), .batch_cnt(cnt_c), .dbg_state(st[2])
  );

  // ---------------- reference model ----------------
  int m_w     [NI][NW];
  int m_acc   [NI][NW];
  int m_init  [NI][NW];
  int m_cnt   [NI];
  int m_batch [NI];
  bit m_sat   [NI][NW];
  bit m_apply [NI];
  bit m_wv    [NI];

  function automatic logic [63:0] model_flat(input int i);
    logic [63:0] r;
    for (int k = 0; k < NW; k++) r[k*16 +: 16] = 16'(m_w[i][k]);
    return r;
  endfunction

  function automatic logic [3:0] model_sat(input int i);
    logic [3:0] r;
    for (int k = 0; k < NW; k++) r[k] = m_sat[i][k];
    return r;
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  // One bank's reaction to the inputs present at a rising edge.
  task automatic model_edge(input int i);
    int s;
    if (rst[i]) begin
      for (int k = 0; k < NW; k++) begin
        m_w[i][k] = 0; m_acc[i][k] = 0; m_sat[i][k] = 0;
      end
      m_cnt[i] = 0; m_apply[i] = 0; m_wv[i] = 0;
    end else begin
      m_wv[i] = 0;
      if (init[i]) begin
        for (int k = 0; k < NW; k++) begin
          m_w[i][k] = m_init[i][k]; m_acc[i][k] = 0; m_sat[i][k] = 0;
        end
        m_cnt[i] = 0; m_apply[i] = 0;
      end else if (m_apply[i]) begin
        for (int k = 0; k < NW; k++) begin
          s = m_w[i][k] + m_acc[i][k];
          if (s > 32767) begin s = 32767; m_sat[i][k] = 1; end
          if (s < -32768) begin s = -32768; m_sat[i][k] = 1; end
          m_w[i][k] = s;
          m_acc[i][k] = 0;
        end
        m_cnt[i] = 0; m_wv[i] = 1; m_apply[i] = 0;
      end else if (uv[i]) begin
        for (int k = 0; k < NW; k++) m_acc[i][k] += int'($signed(dw[i][k*16 +: 16]));
        m_cnt[i]++;
        if (m_cnt[i] == m_batch[i]) m_apply[i] = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
  endtask

  task automatic set_idle();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; init[i] = 1'b0; uv[i] = 1'b0; dw[i] = '0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    tick(); tick();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (wf[i] !== 64'h0) begin
        n_fail++; $display("FAIL reset_w inst=%0d got=%h exp=0", i, wf[i]);
      end
      n_checks++;
      if (wv[i] !== 1'b0 || sf[i] !== 4'h0 || dut_cnt(i) != 0 || rdy[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ctl inst=%0d wv=%b sf=%b cnt=%0d rdy=%b exp 0/0/0/1",
                 i, wv[i], sf[i], dut_cnt(i), rdy[i]);
      end
      n_checks++;
      if (st[i] !== ST_ACCUM) begin
        n_fail++; $display("FAIL reset_state inst=%0d got=%0d exp=ACCUM", i, st[i]);
      end
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < NI; i++) init[i] = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) init[i] = 1'b0;
    n_checks++;
    if (wf[0] !== {4{16'h0266}} || wv[0] !== 1'b0 || sf[0] !== 4'h0) begin
      n_fail++; $display("FAIL init_b1 w=%h wv=%b sf=%b exp w=%h", wf[0], wv[0], sf[0], {4{16'h0266}});
    end
    for (int i = 1; i < NI; i++) begin
      n_checks++;
      if (wf[i] !== model_flat(i)) begin
        n_fail++; $display("FAIL init_w inst=%0d got=%h exp=%h", i, wf[i], model_flat(i));
      end
    end
  endtask

  task automatic test_batch1();
    dw[0] = {4{16'h0010}}; uv[0] = 1'b1;
    tick();
    uv[0] = 1'b0;
    n_checks++;
    if (wf[0] !== {4{16'h0266}} || rdy[0] !== 1'b0 || wv[0] !== 1'b0) begin
      n_fail++; $display("FAIL b1_accept w=%h rdy=%b wv=%b exp w unchanged rdy=0 wv=0", wf[0], rdy[0], wv[0]);
    end
    tick();
    n_checks++;
    if (wf[0] !== {4{16'h0276}} || wv[0] !== 1'b1) begin
      n_fail++; $display("FAIL b1_commit w=%h wv=%b exp w=%h wv=1", wf[0], wv[0], {4{16'h0276}});
    end
    tick();
    n_checks++;
    if (wv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL b1_pulse wv=%b rdy=%b exp wv=0 rdy=1", wv[0], rdy[0]);
    end
    dw[0] = {4{16'hFFF0}}; uv[0] = 1'b1;
    tick();
    uv[0] = 1'b0;
    tick();
    n_checks++;
    if (wf[0] !== {4{16'h0266}} || wv[0] !== 1'b1) begin
      n_fail++; $display("FAIL b1_neg w=%h wv=%b exp w=%h wv=1", wf[0], wv[0], {4{16'h0266}});
    end
  endtask

  task automatic test_batch4();
    int pulses;
    pulses = 0;
    dw[1] = {4{16'h0001}}; uv[1] = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      tick();
      if (wv[1] === 1'b1) pulses++;
      n_checks++;
      if (dut_cnt(1) != s || wf[1] !== {4{16'h0266}}) begin
        n_fail++; $display("FAIL b4_cnt step=%0d cnt=%0d w=%h exp cnt=%0d w unchanged", s, dut_cnt(1), wf[1], s);
      end
    end
    n_checks++;
    if (rdy[1] !== 1'b0) begin
      n_fail++; $display("FAIL b4_ready got=%b exp=0", rdy[1]);
    end
    tick();                    // valid still high in APPLY: must be ignored
    uv[1] = 1'b0;
    if (wv[1] === 1'b1) pulses++;
    n_checks++;
    if (wf[1] !== {4{16'h026A}} || dut_cnt(1) != 0 || rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL b4_commit w=%h cnt=%0d rdy=%b exp w=%h cnt=0 rdy=1", wf[1], dut_cnt(1), rdy[1], {4{16'h026A}});
    end
    tick();
    if (wv[1] === 1'b1) pulses++;
    tick();
    if (wv[1] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL b4_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_saturation();
    dw[2] = {16'hFFFF, 16'h0001, 16'hFF00, 16'h0100}; uv[2] = 1'b1;
    tick();
    uv[2] = 1'b0;
    tick();
    n_checks++;
    if (wf[2] !== {16'hFFFF, 16'h0101, 16'h8000, 16'h7FFF}) begin
      n_fail++; $display("FAIL sat_w got=%h exp=%h", wf[2], {16'hFFFF, 16'h0101, 16'h8000, 16'h7FFF});
    end
    n_checks++;
    if (sf[2] !== 4'b0011) begin
      n_fail++; $display("FAIL sat_flag got=%b exp=0011", sf[2]);
    end
    dw[2] = '0; uv[2] = 1'b1;
    tick();
    uv[2] = 1'b0;
    tick();
    n_checks++;
    if (sf[2] !== 4'b0011 || wf[2] !== model_flat(2)) begin
      n_fail++; $display("FAIL sat_sticky sf=%b w=%h exp sf=0011 w=%h", sf[2], wf[2], model_flat(2));
    end
    init[2] = 1'b1;
    tick();
    init[2] = 1'b0;
    n_checks++;
    if (sf[2] !== 4'b0000) begin
      n_fail++; $display("FAIL sat_clear got=%b exp=0000", sf[2]);
    end
  endtask

  task automatic test_collisions();
    dw[1] = {4{16'h0001}}; uv[1] = 1'b1;
    tick(); tick();
    dw[1] = {4{16'h0100}}; init[1] = 1'b1;
    tick();
    init[1] = 1'b0; uv[1] = 1'b0;
    n_checks++;
    if (wf[1] !== {4{16'h0266}} || dut_cnt(1) != 0 || rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL coll_init_valid w=%h cnt=%0d rdy=%b exp w=%h cnt=0 rdy=1", wf[1], dut_cnt(1), rdy[1], {4{16'h0266}});
    end
    tick();
    n_checks++;
    if (dut_cnt(1) != 0) begin
      n_fail++; $display("FAIL coll_dropped cnt=%0d exp=0", dut_cnt(1));
    end
    dw[0] = {4{16'h0100}}; uv[0] = 1'b1;
    tick();
    uv[0] = 1'b0; init[0] = 1'b1;
    tick();
    init[0] = 1'b0;
    n_checks++;
    if (wf[0] !== {4{16'h0266}} || wv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      n_fail++; $display("FAIL coll_init_apply w=%h wv=%b rdy=%b exp w=%h wv=0 rdy=1", wf[0], wv[0], rdy[0], {4{16'h0266}});
    end
    tick();
    n_checks++;
    if (wv[0] !== 1'b0 || wf[0] !== {4{16'h0266}}) begin
      n_fail++; $display("FAIL coll_no_pulse wv=%b w=%h exp wv=0", wv[0], wf[0]);
    end
  endtask

  task automatic test_reset_mid_batch();
    dw[1] = {4{16'h0001}}; uv[1] = 1'b1;
    tick(); tick();
    uv[1] = 1'b0; rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    n_checks++;
    if (wf[1] !== 64'h0 || dut_cnt(1) != 0) begin
      n_fail++; $display("FAIL midrst w=%h cnt=%0d exp w=0 cnt=0", wf[1], dut_cnt(1));
    end
    init[1] = 1'b1;
    tick();
    init[1] = 1'b0;
    dw[1] = {4{16'h0003}}; uv[1] = 1'b1;
    repeat (4) tick();
    uv[1] = 1'b0;
    tick();
    n_checks++;
    if (wf[1] !== {4{16'h0272}} || wv[1] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_commit w=%h wv=%b exp w=%h wv=1", wf[1], wv[1], {4{16'h0272}});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst[i]  = ($urandom_range(0, 99) == 0);
        init[i] = ($urandom_range(0, 39) == 0);
        uv[i]   = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < NW; k++) begin
          if ($urandom_range(0, 3) == 0) dw[i][k*16 +: 16] = 16'($urandom);
          else dw[i][k*16 +: 16] = 16'($signed($urandom_range(0, 255)) - 128);
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (wf[i] !== model_flat(i)) begin
          n_fail++; $display("FAIL rand_w cyc=%0d inst=%0d got=%h exp=%h", c, i, wf[i], model_flat(i));
        end
        n_checks++;
        if (wv[i] !== m_wv[i] || sf[i] !== model_sat(i) || dut_cnt(i) != m_cnt[i] || rdy[i] !== !m_apply[i]) begin
          n_fail++;
          $display("FAIL rand_ctl cyc=%0d inst=%0d wv=%b/%b sf=%b/%b cnt=%0d/%0d rdy=%b/%b (got/exp)",
                   c, i, wv[i], m_wv[i], sf[i], model_sat(i), dut_cnt(i), m_cnt[i], rdy[i], !m_apply[i]);
        end
      end
    end
    set_idle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_batch[0] = 1; m_batch[1] = 4; m_batch[2] = 1;
    for (int k = 0; k < NW; k++) begin
      m_init[0][k] = 614;      // 0x0266
      m_init[1][k] = 614;
    end
    m_init[2][0] = 32752;      // 0x7FF0
    m_init[2][1] = -32752;     // 0x8010
    m_init[2][2] = 256;        // 0x0100
    m_init[2][3] = 0;
    set_idle();
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    test_reset();
    test_init();
    test_batch1();
    test_batch4();
    test_saturation();
    test_collisions();
    test_reset_mid_batch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
